// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types and helpers for the alarm sequencer.
//   alarm_state_t : sequencer states (IDLE, RING, SNOOZE)
//   PH_ON, PH_OFF : blink phase encodings
//   cnt_w(limit)  : width of a counter that must reach 'limit' (minimum 1)
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_t;

  localparam logic PH_ON  = 1'b1;
  localparam logic PH_OFF = 1'b0;

  function automatic int cnt_w(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/alarm_pattern_gen.sv
// alarm_pattern_gen: LED pattern generator for the ringing state.
//   Default build: all-ones / all-zeros blink, BLINK_HALF cycles per phase.
//   With ALARM_CHASE_EN defined: walking one, rotating left every BLINK_HALF
//   cycles and starting at bit 0.
// Ports:
//   clk     in  system clock
//   rst     in  synchronous, active-low reset
//   restart in  first cycle of a ringing period: reload pattern, clear phase
//   enable  in  ringing continues this cycle
//   pattern out registered LED drive, zero whenever not enabled
module alarm_pattern_gen
  import alarm_pkg::*;
#(
  parameter int LED_WIDTH  = 18,
  parameter int BLINK_HALF = 2500000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  input  logic                 enable,
  output logic [LED_WIDTH-1:0] pattern
);

  localparam int PW = cnt_w(BLINK_HALF);
  localparam logic [PW-1:0] PH_LAST = PW'(BLINK_HALF - 1);

  logic [PW-1:0] phase_cnt;
  logic          wrap;

  assign wrap = (phase_cnt == PH_LAST);

`ifdef ALARM_CHASE_EN
  // The pattern register itself carries the walking one while ringing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_cnt <= '0;
      pattern   <= '0;
    end else if (restart) begin
      phase_cnt <= '0;
      pattern   <= LED_WIDTH'(1);
    end else if (enable) begin
      if (wrap) begin
        phase_cnt <= '0;
        // Rotate left; for LED_WIDTH==1 both terms collapse to the same bit.
        pattern   <= (pattern << 1) | (pattern >> (LED_WIDTH - 1));
      end else begin
        phase_cnt <= phase_cnt + 1'b1;
      end
    end else begin
      phase_cnt <= '0;
      pattern   <= '0;
    end
  end
`else
  logic phase;

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_cnt <= '0;
      phase     <= PH_ON;
      pattern   <= '0;
    end else if (restart) begin
      phase_cnt <= '0;
      phase     <= PH_ON;
      pattern   <= '1;
    end else if (enable) begin
      if (wrap) begin
        phase_cnt <= '0;
        phase     <= ~phase;
        pattern   <= (phase == PH_ON) ? '0 : '1;
      end else begin
        phase_cnt <= phase_cnt + 1'b1;
      end
    end else begin
      phase_cnt <= '0;
      phase     <= PH_ON;
      pattern   <= '0;
    end
  end
`endif

endmodule

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: alarm output driver between alarm-compare and the LED bank.
// A rising edge on alarm_trigger starts a ringing session with a timed blink;
// the user may stop it or snooze it (up to MAX_SNOOZE times), and an
// unattended session times out after ALARM_TIME cycles, setting 'missed'.
// Optional build macro: ALARM_CHASE_EN (walking-one pattern instead of blink).
// Ports:
//   clk           in  system clock
//   rst           in  synchronous, active-low reset
//   alarm_trigger in  level from alarm compare, rising edge starts a session
//   stop          in  single-cycle user stop pulse
//   snooze        in  single-cycle user snooze pulse
//   alarm_signal  out LED drive pattern (LED_WIDTH bits)
//   ringing       out high while in RING
//   snoozed       out high while in SNOOZE
//   missed        out sticky, last session timed out unattended
//
// state  | meaning
// IDLE   | silent, waiting for a trigger rising edge
// RING   | LED pattern active, ring timer running
// SNOOZE | silent, snooze timer running, resumes RING on expiry
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int LED_WIDTH   = 18,
  parameter int ALARM_TIME  = 10000000,
  parameter int BLINK_HALF  = 2500000,
  parameter int SNOOZE_TIME = 50000000,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alarm_trigger,
  input  logic                 stop,
  input  logic                 snooze,
  output logic [LED_WIDTH-1:0] alarm_signal,
  output logic                 ringing,
  output logic                 snoozed,
  output logic                 missed
);

  localparam int RW = cnt_w(ALARM_TIME);
  localparam int NW = cnt_w(SNOOZE_TIME);
  localparam int SW = cnt_w(MAX_SNOOZE);
  localparam logic [RW-1:0] RING_LAST = RW'(ALARM_TIME - 1);
  localparam logic [NW-1:0] SNZ_LAST  = NW'(SNOOZE_TIME - 1);
  localparam logic [SW-1:0] SNZ_MAX   = SW'(MAX_SNOOZE);

  alarm_state_t  state, nxt_state;
  logic          trig_q;
  logic          start;
  logic [RW-1:0] ring_cnt;
  logic [NW-1:0] snz_cnt;
  logic [SW-1:0] snz_num;
  logic          pat_restart;
  logic          pat_enable;

  assign start = alarm_trigger & ~trig_q;

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE: begin
        if (start) nxt_state = RING;
      end
      RING: begin
        if (stop)                            nxt_state = IDLE;
        else if (snooze && snz_num < SNZ_MAX) nxt_state = SNOOZE;
        else if (ring_cnt == RING_LAST)      nxt_state = IDLE;
      end
      SNOOZE: begin
        if (stop)                     nxt_state = IDLE;
        else if (snz_cnt == SNZ_LAST) nxt_state = RING;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Pattern generator is driven from the next state so its registered output
  // lines up with the registered ringing/snoozed flags.
  assign pat_enable  = (nxt_state == RING);
  assign pat_restart = (nxt_state == RING) && (state != RING);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      trig_q   <= 1'b0;
      ring_cnt <= '0;
      snz_cnt  <= '0;
      snz_num  <= '0;
      ringing  <= 1'b0;
      snoozed  <= 1'b0;
      missed   <= 1'b0;
    end else begin
      state   <= nxt_state;
      trig_q  <= alarm_trigger;
      ringing <= (nxt_state == RING);
      snoozed <= (nxt_state == SNOOZE);

      if (pat_restart)
        ring_cnt <= '0;
      else if (state == RING && nxt_state == RING)
        ring_cnt <= ring_cnt + 1'b1;

      if (nxt_state == SNOOZE && state != SNOOZE)
        snz_cnt <= '0;
      else if (state == SNOOZE && nxt_state == SNOOZE)
        snz_cnt <= snz_cnt + 1'b1;

      if (state == IDLE && start) begin
        snz_num <= '0;
        missed  <= 1'b0;
      end

      if (state == RING && nxt_state == SNOOZE)
        snz_num <= snz_num + 1'b1;

      // Leaving RING for IDLE without a stop can only be the timeout.
      if (state == RING && nxt_state == IDLE && !stop)
        missed <= 1'b1;
    end
  end

  alarm_pattern_gen #(
    .LED_WIDTH  (LED_WIDTH),
    .BLINK_HALF (BLINK_HALF)
  ) u_pattern (
    .clk     (clk),
    .rst     (rst),
    .restart (pat_restart),
    .enable  (pat_enable),
    .pattern (alarm_signal)
  );

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: directed bench for alarm_sequencer with
// LED_WIDTH=4, ALARM_TIME=20, BLINK_HALF=3, SNOOZE_TIME=10, MAX_SNOOZE=2.
// Step k below means the k-th rising edge after start was sampled;
// outputs are sampled 1 time unit after each edge.
module tb_alarm_sequencer;

  logic       clk;
  logic       rst;
  logic       alarm_trigger;
  logic       stop;
  logic       snooze;
  logic [3:0] alarm_signal;
  logic       ringing;
  logic       snoozed;
  logic       missed;

  int checks = 0;
  int errors = 0;
  int r;

  alarm_sequencer #(
    .LED_WIDTH   (4),
    .ALARM_TIME  (20),
    .BLINK_HALF  (3),
    .SNOOZE_TIME (10),
    .MAX_SNOOZE  (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .alarm_trigger (alarm_trigger),
    .stop          (stop),
    .snooze        (snooze),
    .alarm_signal  (alarm_signal),
    .ringing       (ringing),
    .snoozed       (snoozed),
    .missed        (missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected pattern on ring cycle k (k=1 is the first ringing cycle).
  function automatic logic [3:0] exp_pat(input int k);
    int slot;
    logic [3:0] one;
    slot = (k - 1) / 3;
    one  = 4'b0001;
`ifdef ALARM_CHASE_EN
    return one << (slot % 4);
`else
    return (slot % 2 == 0) ? 4'hF : 4'h0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    alarm_trigger = 1'b0;
    stop = 1'b0;
    snooze = 1'b0;
    step();
    step();
    chk("reset_alarm", 32'(alarm_signal), 32'h0);
    chk("reset_ringing", 32'(ringing), 32'h0);
    chk("reset_snoozed", 32'(snoozed), 32'h0);
    chk("reset_missed", 32'(missed), 32'h0);
    rst = 1'b1;
    step();
    chk("idle_ringing", 32'(ringing), 32'h0);

    // Unattended session: 20 ringing cycles then timeout.
    alarm_trigger = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("t1_pat_%0d", k), 32'(alarm_signal), 32'(exp_pat(k)));
      chk($sformatf("t1_ring_%0d", k), 32'(ringing), 32'h1);
    end
    step();
    chk("t1_timeout_ringing", 32'(ringing), 32'h0);
    chk("t1_timeout_alarm", 32'(alarm_signal), 32'h0);
    chk("t1_missed", 32'(missed), 32'h1);
    step();
    chk("t1_missed_sticky", 32'(missed), 32'h1);
    chk("t1_no_retrigger", 32'(ringing), 32'h0);

    // Snooze session: two accepted snoozes, third ignored, then timeout.
    alarm_trigger = 1'b0;
    step();
    alarm_trigger = 1'b1;
    step();
    chk("t2_start_ring", 32'(ringing), 32'h1);
    chk("t2_missed_clear", 32'(missed), 32'h0);
    step();
    step();
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    chk("t2_snz1_snoozed", 32'(snoozed), 32'h1);
    chk("t2_snz1_ringing", 32'(ringing), 32'h0);
    chk("t2_snz1_alarm", 32'(alarm_signal), 32'h0);
    for (int k = 2; k <= 10; k++) begin
      step();
      chk($sformatf("t2_snz1_hold_%0d", k), 32'(snoozed), 32'h1);
    end
    step();
    chk("t2_resume1_ring", 32'(ringing), 32'h1);
    chk("t2_resume1_snoozed", 32'(snoozed), 32'h0);
    chk("t2_resume1_pat", 32'(alarm_signal), 32'(exp_pat(1)));
    for (int k = 2; k <= 4; k++) begin
      step();
      chk($sformatf("t2_resume1_pat_%0d", k), 32'(alarm_signal), 32'(exp_pat(k)));
    end
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    chk("t2_snz2_snoozed", 32'(snoozed), 32'h1);
    for (int k = 2; k <= 10; k++) step();
    chk("t2_snz2_last", 32'(snoozed), 32'h1);
    step();
    chk("t2_resume2_ring", 32'(ringing), 32'h1);
    r = 1;
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    r++;
    chk("t3_snz3_ignored_ring", 32'(ringing), 32'h1);
    chk("t3_snz3_ignored_snoozed", 32'(snoozed), 32'h0);
    chk("t3_snz3_pat", 32'(alarm_signal), 32'(exp_pat(r)));
    while (r < 20) begin
      step();
      r++;
      chk($sformatf("t3_ring_%0d", r), 32'(ringing), 32'h1);
    end
    step();
    chk("t3_timeout_ringing", 32'(ringing), 32'h0);
    chk("t3_timeout_missed", 32'(missed), 32'h1);

    // stop and snooze together: stop wins, no missed.
    alarm_trigger = 1'b0;
    step();
    alarm_trigger = 1'b1;
    step();
    chk("t4_ring", 32'(ringing), 32'h1);
    stop = 1'b1;
    snooze = 1'b1;
    step();
    stop = 1'b0;
    snooze = 1'b0;
    chk("t4_stop_ringing", 32'(ringing), 32'h0);
    chk("t4_stop_snoozed", 32'(snoozed), 32'h0);
    chk("t4_stop_alarm", 32'(alarm_signal), 32'h0);
    chk("t4_stop_missed", 32'(missed), 32'h0);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    chk("t4_idle_snooze_ignored", 32'(snoozed), 32'h0);

    // Stop during SNOOZE returns to IDLE.
    alarm_trigger = 1'b0;
    step();
    alarm_trigger = 1'b1;
    step();
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    chk("t4b_snoozed", 32'(snoozed), 32'h1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t4b_stop_snoozed", 32'(snoozed), 32'h0);
    chk("t4b_stop_ringing", 32'(ringing), 32'h0);

    // Reset mid-SNOOZE with trigger held high.
    alarm_trigger = 1'b0;
    step();
    alarm_trigger = 1'b1;
    step();
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    step();
    chk("t5_pre_snoozed", 32'(snoozed), 32'h1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t5_rst_alarm", 32'(alarm_signal), 32'h0);
    chk("t5_rst_ringing", 32'(ringing), 32'h0);
    chk("t5_rst_snoozed", 32'(snoozed), 32'h0);
    chk("t5_rst_missed", 32'(missed), 32'h0);
    step();
    chk("t5_restart_ring", 32'(ringing), 32'h1);
    chk("t5_restart_pat", 32'(alarm_signal), 32'(exp_pat(1)));
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t5_final_idle", 32'(ringing), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
